// File: rtl/cotm32_pipeline_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// bundle of stall/flush controls driven onto the four pipeline registers.
package cotm32_pipeline_pkg;

    typedef enum logic [1:0] {
        PIPE_RUN        = 2'd0,
        PIPE_TRAP_FLUSH = 2'd1,
        PIPE_MEM_WAIT   = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic exmem_stall;
        logic exmem_flush;
        logic memwb_stall;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Canonical control patterns, one per pipeline situation.
    localparam pipe_ctrl_t CTRL_NONE     = 9'b000000000;
    localparam pipe_ctrl_t CTRL_RESET    = 9'b001010101;
    localparam pipe_ctrl_t CTRL_REDIRECT = 9'b001010100;
    localparam pipe_ctrl_t CTRL_MEM_HOLD = 9'b110101001;
    localparam pipe_ctrl_t CTRL_BRANCH   = 9'b001010000;
    localparam pipe_ctrl_t CTRL_LOAD_USE = 9'b110010000;
    localparam pipe_ctrl_t CTRL_SETTLE   = 9'b001000000;
    localparam pipe_ctrl_t CTRL_TIMEOUT  = 9'b000000100;

    function automatic logic any_flush(input pipe_ctrl_t c);
        return c.ifid_flush | c.idex_flush | c.exmem_flush | c.memwb_flush;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline stages and stall/flush controls back to
// them; the controller is the master, the datapath is the slave.
interface pipe_ctrl_if;

    logic       i_ifid_valid;
    logic       i_idex_valid;
    logic       i_exmem_valid;
    logic [4:0] i_id_rs1_addr;
    logic [4:0] i_id_rs2_addr;
    logic       i_id_uses_rs1;
    logic       i_id_uses_rs2;
    logic [4:0] i_ex_rd_addr;
    logic       i_ex_regfile_we;
    logic       i_ex_is_load;
    logic       i_ex_take_branch;
    logic       i_trap_req;
    logic       i_trap_mret;
    logic       i_mem_busy;

    logic       o_pc_stall;
    logic       o_ifid_stall;
    logic       o_ifid_flush;
    logic       o_idex_stall;
    logic       o_idex_flush;
    logic       o_exmem_stall;
    logic       o_exmem_flush;
    logic       o_memwb_stall;
    logic       o_memwb_flush;

    modport master (
        input  i_ifid_valid, i_idex_valid, i_exmem_valid,
        input  i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
        input  i_ex_rd_addr, i_ex_regfile_we, i_ex_is_load, i_ex_take_branch,
        input  i_trap_req, i_trap_mret, i_mem_busy,
        output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
        output o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush
    );

    modport slave (
        output i_ifid_valid, i_idex_valid, i_exmem_valid,
        output i_id_rs1_addr, i_id_rs2_addr, i_id_uses_rs1, i_id_uses_rs2,
        output i_ex_rd_addr, i_ex_regfile_we, i_ex_is_load, i_ex_take_branch,
        output i_trap_req, i_trap_mret, i_mem_busy,
        input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
        input  o_exmem_stall, o_exmem_flush, o_memwb_stall, o_memwb_flush
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            o_cnt <= '0;
        else if (i_inc && (o_cnt != '1))
            o_cnt <= o_cnt + WIDTH'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: load-use, branch, trap/MRET redirect and
// data-memory wait handling, plus saturating stall/flush event counters.
module pipe_ctrl
    import cotm32_pipeline_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int TRAP_SETTLE = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pipe_ctrl_if.master          bus,
    output logic                 o_t_mem_timeout,
    output logic [1:0]           o_state,
    output logic [CNT_WIDTH-1:0] o_stall_cnt,
    output logic [CNT_WIDTH-1:0] o_flush_cnt
);

    localparam int SETTLE_W = (TRAP_SETTLE > 1) ? $clog2(TRAP_SETTLE) : 1;
    localparam int WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(TRAP_SETTLE - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(MEM_TIMEOUT - 1);

    pipe_state_t         state, state_nxt;
    logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    pipe_ctrl_t          ctrl;
    logic                timeout;
    logic                load_use;
    logic                unused_valids;

    assign unused_valids = bus.i_ifid_valid ^ bus.i_exmem_valid;

    // A single bubble is enough: the consumer forwards from MEM/WB next.
    assign load_use = bus.i_ex_is_load & bus.i_ex_regfile_we & bus.i_idex_valid &
                      (bus.i_ex_rd_addr != 5'd0) &
                      ((bus.i_id_uses_rs1 & (bus.i_id_rs1_addr == bus.i_ex_rd_addr)) |
                       (bus.i_id_uses_rs2 & (bus.i_id_rs2_addr == bus.i_ex_rd_addr)));

    always_comb begin
        ctrl       = CTRL_NONE;
        timeout    = 1'b0;
        state_nxt  = state;
        settle_nxt = settle_cnt;
        wait_nxt   = wait_cnt;
        case (state)
            PIPE_RUN: begin
                if (bus.i_trap_req | bus.i_trap_mret) begin
                    ctrl       = CTRL_REDIRECT;
                    state_nxt  = PIPE_TRAP_FLUSH;
                    settle_nxt = SETTLE_LOAD;
                end else if (bus.i_mem_busy) begin
                    ctrl      = CTRL_MEM_HOLD;
                    state_nxt = PIPE_MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end else if (bus.i_ex_take_branch) begin
                    ctrl = CTRL_BRANCH;
                end else if (load_use) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            PIPE_TRAP_FLUSH: begin
                if (bus.i_trap_req) begin
                    ctrl       = CTRL_REDIRECT;
                    settle_nxt = SETTLE_LOAD;
                end else begin
                    ctrl = CTRL_SETTLE;
                    if (settle_cnt == '0)
                        state_nxt = PIPE_RUN;
                    else
                        settle_nxt = settle_cnt - SETTLE_W'(1);
                end
            end
            PIPE_MEM_WAIT: begin
                if (bus.i_trap_req) begin
                    ctrl       = CTRL_REDIRECT;
                    state_nxt  = PIPE_TRAP_FLUSH;
                    settle_nxt = SETTLE_LOAD;
                    wait_nxt   = '0;
                end else if (!bus.i_mem_busy) begin
                    state_nxt = PIPE_RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt >= WAIT_LAST) begin
                    // Abandon the access; trap dispatch raises the fault.
                    ctrl      = CTRL_TIMEOUT;
                    timeout   = 1'b1;
                    state_nxt = PIPE_RUN;
                    wait_nxt  = '0;
                end else begin
                    ctrl     = CTRL_MEM_HOLD;
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: state_nxt = PIPE_RUN;
        endcase
        if (!i_rst) begin
            ctrl    = CTRL_RESET;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= PIPE_RUN;
            settle_cnt <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            wait_cnt   <= wait_nxt;
        end
    end

    assign bus.o_pc_stall    = ctrl.pc_stall;
    assign bus.o_ifid_stall  = ctrl.ifid_stall;
    assign bus.o_ifid_flush  = ctrl.ifid_flush;
    assign bus.o_idex_stall  = ctrl.idex_stall;
    assign bus.o_idex_flush  = ctrl.idex_flush;
    assign bus.o_exmem_stall = ctrl.exmem_stall;
    assign bus.o_exmem_flush = ctrl.exmem_flush;
    assign bus.o_memwb_stall = ctrl.memwb_stall;
    assign bus.o_memwb_flush = ctrl.memwb_flush;
    assign o_t_mem_timeout   = timeout;
    assign o_state           = state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (ctrl.pc_stall),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (any_flush(ctrl) & i_rst),
        .o_cnt (o_flush_cnt)
    );

endmodule
